fifo_stream_adapter: RTL and testbench

Downstream drain stage for the `fifo` block used in Lease Cache memory controller testing. It converts the FIFO's pop interface into a valid/ready stream for the controller-side consumer. The FIFO's pop interface is `rd_en` in, `dout` returned a fixed number of cycles later, plus the `empty` flag. The block tracks reads in flight and buffers returned words in a small skid buffer. It sustains one word per cycle without losing or duplicating data under back-pressure.

---
 rtl/fifo_stream_adapter.sv | 95 +++++++++
 tb/tb_fifo_stream_adapter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_adapter.sv
// rtl/fifo_stream_adapter.sv - FIFO pop interface to valid/ready stream drain stage with skid buffer
// Reads are credited against buffer space so returned words always have a slot.
module fifo_stream_adapter #(
    parameter int width  = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             fifo_empty_i,
    input  logic [width-1:0] fifo_dout_i,
    output logic             fifo_rd_en_o,
    output logic             m_valid_o,
    output logic [width-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] xfer_count_o
);

    localparam int BUF_DEPTH = RD_LAT + 2;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    // One spare bit so occ + inflight never overflows before the compare
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1) + 1;
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(BUF_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [width-1:0]  r_buf [BUF_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [OCC_W-1:0]  r_occ;
    logic [RD_LAT-1:0] r_pend;
    logic [CNT_W-1:0]  r_xfer;

    logic [OCC_W-1:0]  w_inflight;
    logic [RD_LAT-1:0] w_pend_next;
    logic              w_rd_en;
    logic              w_capture;
    logic              w_accept;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + OCC_W'(r_pend[i]);
        end
    end

    always_comb begin
        w_pend_next    = r_pend << 1;
        w_pend_next[0] = w_rd_en;
    end

    assign w_rd_en   = ~reset_i & enable_i & ~fifo_empty_i & ((r_occ + w_inflight) < DEPTH_C);
    assign w_capture = r_pend[RD_LAT-1];
    assign w_accept  = (r_occ != '0) & m_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_pend <= '0;
            r_xfer <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (w_capture) begin
                r_buf[r_tail] <= fifo_dout_i;
                r_tail        <= (r_tail == LAST_PTR) ? '0 : r_tail + PTR_ONE;
            end
            if (w_accept) begin
                r_head <= (r_head == LAST_PTR) ? '0 : r_head + PTR_ONE;
                r_xfer <= r_xfer + CNT_ONE;
            end
            // Capture and accept together leave occupancy unchanged
            case ({w_capture, w_accept})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign fifo_rd_en_o = w_rd_en;
    assign m_valid_o    = (r_occ != '0);
    assign m_data_o     = r_buf[r_head];
    assign busy_o       = (r_occ != '0) | (|r_pend);
    assign xfer_count_o = r_xfer;

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb/tb_fifo_stream_adapter.sv - scoreboard bench for fifo_stream_adapter
// Two instances: A (RD_LAT=1, CNT_W=16) for directed timing, B (RD_LAT=2, CNT_W=4) for wrap/random ready.
module tb_fifo_stream_adapter;

    logic clk_i = 1'b0;
    logic rst   = 1'b1;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Instance A signals and FIFO model
    logic        a_enable = 1'b1;
    logic        a_empty;
    logic [7:0]  a_dout = 8'hEE;
    logic        a_rd_en;
    logic        a_valid;
    logic [7:0]  a_data;
    logic        a_ready = 1'b1;
    logic        a_busy;
    logic [15:0] a_xfer;
    logic [7:0]  a_mem [64];
    int          a_wr = 0;
    int          a_rd = 0;
    logic [7:0]  a_exp [$];
    logic [7:0]  a_e;

    // Instance B signals and FIFO model
    logic        b_empty;
    logic [7:0]  b_d1 = 8'hEE;
    logic [7:0]  b_dout = 8'hEE;
    logic        b_rd_en;
    logic        b_valid;
    logic [7:0]  b_data;
    logic        b_ready = 1'b0;
    logic        b_busy;
    logic [3:0]  b_xfer;
    logic [7:0]  b_mem [64];
    int          b_wr = 0;
    int          b_rd = 0;
    int          b_iss = 0;
    int          b_acc = 0;
    logic [7:0]  b_exp [$];
    logic [7:0]  b_e;
    bit          b_active = 1'b0;

    fifo_stream_adapter #(.width(8), .RD_LAT(1), .CNT_W(16)) u_a (
        .clk_i(clk_i), .reset_i(rst), .enable_i(a_enable), .fifo_empty_i(a_empty),
        .fifo_dout_i(a_dout), .fifo_rd_en_o(a_rd_en), .m_valid_o(a_valid), .m_data_o(a_data),
        .m_ready_i(a_ready), .busy_o(a_busy), .xfer_count_o(a_xfer)
    );

    fifo_stream_adapter #(.width(8), .RD_LAT(2), .CNT_W(4)) u_b (
        .clk_i(clk_i), .reset_i(rst), .enable_i(1'b1), .fifo_empty_i(b_empty),
        .fifo_dout_i(b_dout), .fifo_rd_en_o(b_rd_en), .m_valid_o(b_valid), .m_data_o(b_data),
        .m_ready_i(b_ready), .busy_o(b_busy), .xfer_count_o(b_xfer)
    );

    assign a_empty = (a_wr == a_rd);
    assign b_empty = (b_wr == b_rd);

    always @(posedge clk_i) begin
        if (a_rd_en) begin
            a_dout <= a_mem[a_rd[5:0]];
            a_rd   <= a_rd + 1;
        end else begin
            a_dout <= 8'hEE;
        end
        if (b_rd_en) begin
            b_d1 <= b_mem[b_rd[5:0]];
            b_rd <= b_rd + 1;
        end else begin
            b_d1 <= 8'hEE;
        end
        b_dout <= b_d1;
    end

    always @(posedge clk_i or posedge rst) begin
        if (rst) begin
            b_iss <= 0;
            b_acc <= 0;
        end else begin
            if (b_rd_en) b_iss <= b_iss + 1;
            if (b_valid && b_ready) b_acc <= b_acc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst && a_valid && a_ready) begin
            if (a_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_word: got 0x%02h expected no word", a_data);
            end else begin
                a_e = a_exp.pop_front();
                chk("a_order", {24'd0, a_data}, {24'd0, a_e});
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst && b_valid && b_ready) begin
            if (b_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_word: got 0x%02h expected no word", b_data);
            end else begin
                b_e = b_exp.pop_front();
                chk("b_order", {24'd0, b_data}, {24'd0, b_e});
            end
        end
        if (b_active) chk("b_credit_bound", 32'(b_iss - b_acc <= 4), 32'd1);
    end

    task automatic load_a(input logic [7:0] v, input bit expect_it);
        a_mem[a_wr[5:0]] = v;
        a_wr = a_wr + 1;
        if (expect_it) a_exp.push_back(v);
    endtask

    task automatic load_b(input logic [7:0] v);
        b_mem[b_wr[5:0]] = v;
        b_wr = b_wr + 1;
        b_exp.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    logic [15:0] rd_pat;
    logic [15:0] val_pat;
    int          cyc;

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_a_rd_en", 32'(a_rd_en), 0);
        chk("rst_a_valid", 32'(a_valid), 0);
        chk("rst_a_data",  32'(a_data), 0);
        chk("rst_a_busy",  32'(a_busy), 0);
        chk("rst_a_xfer",  32'(a_xfer), 0);
        chk("rst_b_busy",  32'(b_busy), 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single word
        load_a(8'hA5, 1'b1);
        rd_pat = '0; val_pat = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            rd_pat[c] = a_rd_en; val_pat[c] = a_valid;
            if (c == 2) chk("single_data", 32'(a_data), 32'hA5);
            next_cycle();
        end
        chk("single_rd_pattern", 32'(rd_pat), 32'h1);
        chk("single_valid_pattern", 32'(val_pat), 32'h4);
        chk("single_xfer", 32'(a_xfer), 1);
        chk("single_busy_idle", 32'(a_busy), 0);

        // Streaming
        for (int i = 1; i <= 8; i++) load_a(8'(i), 1'b1);
        rd_pat = '0; val_pat = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            rd_pat[c] = a_rd_en; val_pat[c] = a_valid;
            next_cycle();
        end
        chk("stream_rd_pattern", 32'(rd_pat), 32'h0FF);
        chk("stream_valid_pattern", 32'(val_pat), 32'h3FC);
        chk("stream_xfer", 32'(a_xfer), 9);

        // Back-pressure
        a_ready = 1'b0;
        for (int i = 1; i <= 8; i++) load_a(8'(i), 1'b1);
        rd_pat = '0; val_pat = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk_i);
            rd_pat[c] = a_rd_en; val_pat[c] = a_valid;
            if (c >= 3 && c <= 5) chk("bp_hold_data", 32'(a_data), 32'h01);
            next_cycle();
            if (c == 5) a_ready = 1'b1;
        end
        chk("bp_rd_pattern", 32'(rd_pat), 32'h0F87);
        chk("bp_valid_pattern", 32'(val_pat[14:6]), 32'h0FF);
        chk("bp_xfer", 32'(a_xfer), 17);

        // Enable deassert mid-burst
        for (int i = 0; i < 6; i++) load_a(8'h11 + 8'(i), 1'b1);
        rd_pat = '0; val_pat = '0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk_i);
            rd_pat[c] = a_rd_en; val_pat[c] = a_valid;
            next_cycle();
            if (c == 3) a_enable = 1'b0;
            if (c == 6) a_enable = 1'b1;
        end
        chk("en_rd_pattern", 32'(rd_pat), 32'h18F);
        chk("en_valid_pattern", 32'(val_pat), 32'h63C);
        chk("en_xfer", 32'(a_xfer), 23);

        // Reset with one word in flight
        load_a(8'h55, 1'b0);
        @(negedge clk_i);
        chk("rst_inflight_rd", 32'(a_rd_en), 1);
        next_cycle();
        #1 rst = 1'b1;
        @(negedge clk_i);
        chk("midrst_rd_en", 32'(a_rd_en), 0);
        chk("midrst_valid", 32'(a_valid), 0);
        chk("midrst_data",  32'(a_data), 0);
        chk("midrst_busy",  32'(a_busy), 0);
        chk("midrst_xfer",  32'(a_xfer), 0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk("post_rst_idle", {29'd0, a_rd_en, a_valid, a_busy}, 0);
            next_cycle();
        end
        load_a(8'h66, 1'b1);
        repeat (5) next_cycle();
        chk("post_rst_xfer", 32'(a_xfer), 1);
        chk("a_scoreboard_empty", 32'(a_exp.size()), 0);

        // Instance B: RD_LAT=2, counter wrap, random ready
        b_active = 1'b1;
        for (int i = 0; i < 17; i++) load_b(8'h40 + 8'(i));
        cyc = 0;
        while (b_acc < 17 && cyc < 600) begin
            next_cycle();
            b_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        b_ready = 1'b1;
        repeat (4) next_cycle();
        b_active = 1'b0;
        chk("b_accepted", 32'(b_acc), 17);
        chk("b_xfer_wrap", 32'(b_xfer), 1);
        chk("b_busy_idle", 32'(b_busy), 0);
        chk("b_scoreboard_empty", 32'(b_exp.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
